cv32e40p_hwlp_sequencer: RTL and testbench
==========================================

Name: cv32e40p_hwlp_sequencer

Overview:
- Hardware-loop sequencer for the core.
- Holds start, end and count registers for N_HWLP zero-overhead loops, written from the CSR/lp.* path.
- Monitors the instruction retiring in ID.
- When that instruction is the last one in an active loop body, it redirects fetch to the loop start and decrements the loop count.
- Sits between the ID stage (pc, valid) and the IF stage (jump request, target).

Parameters:
N_HWLP, 2, number of hardware loops (from the shared localparam package)
ADDR_W, 32, instruction address width
CNT_W, 32, loop counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cfg_we_i  in  1  configuration write strobe
cfg_sel_i  in  2  register select: 00 start, 01 end, 10 count, 11 reserved
cfg_idx_i  in  N_HWLP_BITS  loop index for write and read
cfg_wdata_i  in  32  write data
cfg_rdata_o  out  32  combinational readback of the register selected by cfg_idx_i/cfg_sel_i; 0 for sel 11
id_valid_i  in  1  instruction in ID retires this cycle
id_pc_i  in  ADDR_W  pc of the ID instruction
hwlp_clear_i  in  1  clear all counts (debug entry, exception)
hwlp_jump_o  out  1  fetch redirect request
hwlp_target_o  out  ADDR_W  redirect target
hwlp_active_o  out  N_HWLP  bit i = (cnt[i] != 0)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - start[i], end[i] and cnt[i] reset to 0 for every i.
  - As a result, hwlp_jump_o=0, hwlp_target_o=0, hwlp_active_o=0 and cfg_rdata_o=0 out of reset.
- Configuration writes:
  - Writes take effect at the next rising edge.
  - Bit 0 of start and end is forced to 0.
  - cfg_sel_i=11 writes are ignored.
- Loop end address: end[i] is the address of the last instruction of the loop body.
- Match: match[i] = id_valid_i & (cnt[i]!=0) & (id_pc_i==end[i]).
- Priority:
  - Loop 0 is the innermost loop and has the highest priority.
  - dec[i] = match[i] & (for all j<i: !match[j] | cnt[j]==1).
  - This lets nested loops that share an end address fall through once the inner loop expires.
- Jump:
  - hwlp_jump_o = OR over i of (dec[i] & cnt[i]>1).
  - hwlp_target_o = start[k], where k is the lowest such i; 0 when there is no jump.
  - Zero-cycle latency: the jump is combinational from registered state and the ID inputs.
- Count update at the edge:
  - cnt[i] <= cnt[i]-1 when dec[i].
  - At cnt==0 there is no decrement and no wrap.
- Priority per count register, at one edge: hwlp_clear_i > config write to that count > decrement. Start/end writes coexist with a clear.
- A write to start/end of an active loop is allowed. The new value is used from the next cycle; in the write cycle the old value drives match/target.
- cnt written as 0 deactivates the loop. cnt written as 1 means a single pass: no jump at the end, the count goes to 0.
- id_valid_i=0 (stall) → no match, no state change; a stalled end instruction is re-evaluated when it retires.
- Reset mid-loop → all loops inactive immediately (asynchronous); no jump asserted.

Decomposition:
- Shared package, alongside the existing localparams: N_HWLP and N_HWLP_BITS (reused), plus enum hwlp_sel_e {HWLP_START=2'b00, HWLP_END=2'b01, HWLP_CNT=2'b10}.
- Sub-module cv32e40p_hwlp_slot, one instance per loop:
  - Contains the start/end/cnt registers, the write-enable decode for its index, and the match/cnt==1 outputs.
  - The top level contains the priority chain, the target mux and readback.

Test Plan:
- Reset then idle: id_valid_i=1, id_pc_i=0 → hwlp_jump_o stays 0, active=00; cfg_rdata_o=0 for all selects.
- Single loop: start0=0x100, end0=0x10C, cnt0=3; retire 0x10C three times → jumps to 0x100 on the first two only, third has no jump, cnt0 sequence 3→2→1→0, active[0] drops after the third.
- Nested shared end: loop0 0x200..0x20C cnt=2, loop1 0x1F0..0x20C cnt=2; retire 0x20C repeatedly → targets 0x200, 0x1F0, 0x200, then no jump; both counts end at 0.
- Collision: write cnt0=5 in the same cycle as a decrementing match (cnt0=3) → cnt0=5 next cycle; with hwlp_clear_i also high → cnt0=0.
- Stall: id_pc_i=end0, id_valid_i=0 for 4 cycles → no jump, cnt unchanged; valid in cycle 5 → one jump, one decrement.
- Mid-loop async reset: drop rst_n between clock edges with cnt0=7 → active=00 and jump=0 immediately, before the next edge.

Source files
------------

// File: rtl/cv32e40p_hwlp_sequencer_pkg.sv
// Shared constants and types for the hardware-loop sequencer.
// Loop count, index width and register-select encoding for the configuration port.
package cv32e40p_hwlp_sequencer_pkg;

  localparam int N_HWLP      = 2;
  localparam int N_HWLP_BITS = (N_HWLP > 1) ? $clog2(N_HWLP) : 1;

  typedef enum logic [1:0] {
    HWLP_START = 2'b00,
    HWLP_END   = 2'b01,
    HWLP_CNT   = 2'b10
  } hwlp_sel_e;

  // Instruction addresses are halfword aligned, so bit 0 is never stored.
  function automatic logic [31:0] hwlp_align(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/cv32e40p_hwlp_sequencer_if.sv
// Bundle of the configuration port and the ID/IF-side loop signals.
// The master drives configuration and ID inputs; the sequencer is the slave.
interface cv32e40p_hwlp_sequencer_if
  import cv32e40p_hwlp_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic                   cfg_we_i;
  logic [1:0]             cfg_sel_i;
  logic [N_HWLP_BITS-1:0] cfg_idx_i;
  logic [31:0]            cfg_wdata_i;
  logic [31:0]            cfg_rdata_o;
  logic                   id_valid_i;
  logic [ADDR_W-1:0]      id_pc_i;
  logic                   hwlp_clear_i;
  logic                   hwlp_jump_o;
  logic [ADDR_W-1:0]      hwlp_target_o;
  logic [N_HWLP-1:0]      hwlp_active_o;

  modport master (
    output cfg_we_i, cfg_sel_i, cfg_idx_i, cfg_wdata_i,
    output id_valid_i, id_pc_i, hwlp_clear_i,
    input  cfg_rdata_o, hwlp_jump_o, hwlp_target_o, hwlp_active_o
  );

  modport slave (
    input  cfg_we_i, cfg_sel_i, cfg_idx_i, cfg_wdata_i,
    input  id_valid_i, id_pc_i, hwlp_clear_i,
    output cfg_rdata_o, hwlp_jump_o, hwlp_target_o, hwlp_active_o
  );

endinterface

// File: rtl/cv32e40p_hwlp_slot.sv
// One hardware loop: start/end/count registers, index-local write decode,
// and the end-of-body match seen by the priority chain in the top level.
module cv32e40p_hwlp_slot
  import cv32e40p_hwlp_sequencer_pkg::*;
#(
  parameter int IDX    = 0,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_sel,
  input  logic [N_HWLP_BITS-1:0] cfg_idx,
  input  logic [31:0]            cfg_wdata,
  input  logic                   clear,
  input  logic                   id_valid,
  input  logic [ADDR_W-1:0]      id_pc,
  input  logic                   dec,
  output logic [ADDR_W-1:0]      start_addr,
  output logic [ADDR_W-1:0]      end_addr,
  output logic [CNT_W-1:0]       cnt,
  output logic                   match,
  output logic                   cnt_one,
  output logic                   active
);

  logic [ADDR_W-1:0] start_reg, start_next;
  logic [ADDR_W-1:0] end_reg, end_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] wdata_addr;
  logic              sel_hit;
  logic              we_start, we_end, we_cnt;

  assign wdata_addr = ADDR_W'(hwlp_align(cfg_wdata));
  assign sel_hit    = cfg_we && (cfg_idx == N_HWLP_BITS'(IDX));
  assign we_start   = sel_hit && (cfg_sel == HWLP_START);
  assign we_end     = sel_hit && (cfg_sel == HWLP_END);
  assign we_cnt     = sel_hit && (cfg_sel == HWLP_CNT);

  always_comb begin
    start_next = start_reg;
    end_next   = end_reg;
    cnt_next   = cnt_reg;
    if (we_start) start_next = wdata_addr;
    if (we_end)   end_next   = wdata_addr;
    // Clear beats a count write, which beats the loop-end decrement.
    if (clear) begin
      cnt_next = '0;
    end else if (we_cnt) begin
      cnt_next = CNT_W'(cfg_wdata);
    end else if (dec && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg <= '0;
      end_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      start_reg <= start_next;
      end_reg   <= end_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign start_addr = start_reg;
  assign end_addr   = end_reg;
  assign cnt        = cnt_reg;
  assign active     = (cnt_reg != '0);
  assign cnt_one    = (cnt_reg == CNT_W'(1));
  assign match      = id_valid && active && (id_pc == end_reg);

endmodule

// File: rtl/cv32e40p_hwlp_sequencer.sv
// Zero-overhead loop sequencer: watches the retiring ID pc against each loop end
// and redirects fetch to the loop start while the count allows another pass.
module cv32e40p_hwlp_sequencer
  import cv32e40p_hwlp_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  cv32e40p_hwlp_sequencer_if.slave bus
);

  logic [N_HWLP-1:0] match;
  logic [N_HWLP-1:0] cnt_one;
  logic [N_HWLP-1:0] active;
  logic [N_HWLP-1:0] dec;
  logic [N_HWLP-1:0] jump_cand;
  logic [ADDR_W-1:0] start_addr [N_HWLP];
  logic [ADDR_W-1:0] end_addr   [N_HWLP];
  logic [CNT_W-1:0]  cnt        [N_HWLP];
  logic [ADDR_W-1:0] target;
  logic [31:0]       rdata;
  logic              fall_through;

  genvar gi;
  generate
    for (gi = 0; gi < N_HWLP; gi++) begin : g_slot
      cv32e40p_hwlp_slot #(
        .IDX    (gi),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (bus.cfg_we_i),
        .cfg_sel    (bus.cfg_sel_i),
        .cfg_idx    (bus.cfg_idx_i),
        .cfg_wdata  (bus.cfg_wdata_i),
        .clear      (bus.hwlp_clear_i),
        .id_valid   (bus.id_valid_i),
        .id_pc      (bus.id_pc_i),
        .dec        (dec[gi]),
        .start_addr (start_addr[gi]),
        .end_addr   (end_addr[gi]),
        .cnt        (cnt[gi]),
        .match      (match[gi]),
        .cnt_one    (cnt_one[gi]),
        .active     (active[gi])
      );
      // A match on its final pass hands the same end address on to the next outer loop.
      assign jump_cand[gi] = dec[gi] && !cnt_one[gi];
    end
  endgenerate

  always_comb begin
    dec          = '0;
    fall_through = 1'b1;
    for (int i = 0; i < N_HWLP; i++) begin
      dec[i]       = match[i] && fall_through;
      fall_through = fall_through && (!match[i] || cnt_one[i]);
    end
  end

  always_comb begin
    target = '0;
    for (int i = N_HWLP - 1; i >= 0; i--) begin
      if (jump_cand[i]) target = start_addr[i];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      if (bus.cfg_idx_i == N_HWLP_BITS'(i)) begin
        case (bus.cfg_sel_i)
          HWLP_START: rdata = 32'(start_addr[i]);
          HWLP_END:   rdata = 32'(end_addr[i]);
          HWLP_CNT:   rdata = 32'(cnt[i]);
          default:    rdata = '0;
        endcase
      end
    end
  end

  assign bus.hwlp_jump_o   = |jump_cand;
  assign bus.hwlp_target_o = target;
  assign bus.hwlp_active_o = active;
  assign bus.cfg_rdata_o   = rdata;

endmodule

// File: tb/tb_cv32e40p_hwlp_sequencer.sv
// Randomised and directed bench for the hardware-loop sequencer, checked every
// cycle against a loop-level model of the start/end/count registers.
module tb_cv32e40p_hwlp_sequencer;
  import cv32e40p_hwlp_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cv32e40p_hwlp_sequencer_if #(.ADDR_W(32)) bus ();

  cv32e40p_hwlp_sequencer #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] m_start [N_HWLP];
  logic [31:0] m_end   [N_HWLP];
  logic [31:0] m_cnt   [N_HWLP];

  int n_vec = 0;
  int n_err = 0;

  logic              s_jump;
  logic [31:0]       s_target;
  logic [31:0]       s_rdata;
  logic [N_HWLP-1:0] s_active;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_HWLP; i++) begin
      m_start[i] = '0;
      m_end[i]   = '0;
      m_cnt[i]   = '0;
    end
  endtask

  // One clock: drive, compare against the loop model, then advance the model.
  task automatic cyc(input logic we, input logic [1:0] sel, input int idx, input logic [31:0] wd,
                     input logic v, input logic [31:0] pc, input logic clr);
    logic              ej;
    logic [31:0]       et;
    logic [31:0]       er;
    logic [N_HWLP-1:0] ea;
    logic [N_HWLP-1:0] edec;
    @(negedge clk);
    bus.cfg_we_i     = we;
    bus.cfg_sel_i    = sel;
    bus.cfg_idx_i    = idx[N_HWLP_BITS-1:0];
    bus.cfg_wdata_i  = wd;
    bus.id_valid_i   = v;
    bus.id_pc_i      = pc;
    bus.hwlp_clear_i = clr;
    // Walk loops innermost first: an expiring loop passes the end pc outward.
    ej   = 1'b0;
    et   = '0;
    edec = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      if (v && m_cnt[i] != 0 && pc == m_end[i]) begin
        edec[i] = 1'b1;
        if (m_cnt[i] > 1) begin
          ej = 1'b1;
          et = m_start[i];
          break;
        end
      end
    end
    for (int i = 0; i < N_HWLP; i++) ea[i] = (m_cnt[i] != 0);
    case (sel)
      2'b00:   er = m_start[idx];
      2'b01:   er = m_end[idx];
      2'b10:   er = m_cnt[idx];
      default: er = '0;
    endcase
    #1;
    s_jump   = bus.hwlp_jump_o;
    s_target = bus.hwlp_target_o;
    s_rdata  = bus.cfg_rdata_o;
    s_active = bus.hwlp_active_o;
    check("jump",   32'(s_jump),   32'(ej));
    check("target", s_target,      et);
    check("active", 32'(s_active), 32'(ea));
    check("rdata",  s_rdata,       er);
    $display("t=%0t we=%0b sel=%0d idx=%0d wd=%08h v=%0b pc=%08h clr=%0b -> jump=%0b tgt=%08h act=%b rd=%08h",
             $time, we, sel, idx, wd, v, pc, clr, s_jump, s_target, s_active, s_rdata);
    @(posedge clk);
    for (int i = 0; i < N_HWLP; i++) begin
      if (clr)                             m_cnt[i] = '0;
      else if (we && sel == 2'b10 && idx == i) m_cnt[i] = wd;
      else if (edec[i])                    m_cnt[i] = m_cnt[i] - 1;
      if (we && idx == i && sel == 2'b00) m_start[i] = {wd[31:1], 1'b0};
      if (we && idx == i && sel == 2'b01) m_end[i]   = {wd[31:1], 1'b0};
    end
  endtask

  initial begin
    int          ridx;
    logic [1:0]  rsel;
    logic [31:0] rwd;
    logic [31:0] rpc;
    rst_n            = 1'b0;
    bus.cfg_we_i     = 1'b0;
    bus.cfg_sel_i    = 2'b00;
    bus.cfg_idx_i    = '0;
    bus.cfg_wdata_i  = '0;
    bus.id_valid_i   = 1'b0;
    bus.id_pc_i      = '0;
    bus.hwlp_clear_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_jump",   32'(bus.hwlp_jump_o),   32'h0);
    check("rst_active", 32'(bus.hwlp_active_o), 32'h0);
    check("rst_rdata",  bus.cfg_rdata_o,        32'h0);
    rst_n = 1'b1;

    // Idle after reset, including an ignored reserved-select write.
    cyc(1'b1, 2'b11, 0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < N_HWLP; k++) cyc(1'b0, 2'(s), k, 32'h0, 1'b1, 32'h0, 1'b0);
    check("idle_jump", 32'(s_jump), 32'h0);

    // Single loop, three passes; end written with bit 0 set to exercise alignment.
    cyc(1'b1, 2'b00, 0, 32'h100, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b01, 0, 32'h10D, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b10, 0, 32'd3,   1'b0, 32'h0, 1'b0);
    cyc(1'b0, 2'b01, 0, 32'h0,   1'b0, 32'h0, 1'b0);
    check("single_end_align", s_rdata, 32'h10C);
    cyc(1'b0, 2'b10, 0, 32'h0, 1'b1, 32'h10C, 1'b0);
    check("single_j1", 32'(s_jump), 32'h1);
    check("single_t1", s_target, 32'h100);
    check("single_c3", s_rdata, 32'd3);
    cyc(1'b0, 2'b10, 0, 32'h0, 1'b1, 32'h10C, 1'b0);
    check("single_c2", s_rdata, 32'd2);
    cyc(1'b0, 2'b10, 0, 32'h0, 1'b1, 32'h10C, 1'b0);
    check("single_j3", 32'(s_jump), 32'h0);
    check("single_c1", s_rdata, 32'd1);
    cyc(1'b0, 2'b10, 0, 32'h0, 1'b1, 32'h10C, 1'b0);
    check("single_c0", s_rdata, 32'd0);
    check("single_act", 32'(s_active), 32'h0);

    // Nested loops sharing one end address; inner count reloaded inside the outer body.
    cyc(1'b1, 2'b00, 0, 32'h200, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b01, 0, 32'h20C, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b10, 0, 32'd2,   1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b00, 1, 32'h1F0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b01, 1, 32'h20C, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b10, 1, 32'd2,   1'b0, 32'h0, 1'b0);
    cyc(1'b0, 2'b00, 0, 32'h0, 1'b1, 32'h20C, 1'b0);
    check("nest_t1", s_target, 32'h200);
    cyc(1'b0, 2'b00, 0, 32'h0, 1'b1, 32'h20C, 1'b0);
    check("nest_t2", s_target, 32'h1F0);
    cyc(1'b1, 2'b10, 0, 32'd2, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 2'b00, 0, 32'h0, 1'b1, 32'h20C, 1'b0);
    check("nest_t3", s_target, 32'h200);
    cyc(1'b0, 2'b00, 0, 32'h0, 1'b1, 32'h20C, 1'b0);
    check("nest_j4", 32'(s_jump), 32'h0);
    cyc(1'b0, 2'b10, 1, 32'h0, 1'b0, 32'h0, 1'b0);
    check("nest_c1", s_rdata, 32'd0);
    check("nest_act", 32'(s_active), 32'h0);

    // Count write and clear colliding with a decrementing match.
    cyc(1'b1, 2'b00, 0, 32'h300, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b01, 0, 32'h30C, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b10, 0, 32'd3,   1'b0, 32'h0, 1'b0);
    cyc(1'b1, 2'b10, 0, 32'd5,   1'b1, 32'h30C, 1'b0);
    check("coll_j", 32'(s_jump), 32'h1);
    cyc(1'b0, 2'b10, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("coll_c5", s_rdata, 32'd5);
    cyc(1'b1, 2'b10, 0, 32'd5, 1'b1, 32'h30C, 1'b1);
    cyc(1'b0, 2'b10, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("coll_clr", s_rdata, 32'd0);

    // Stalled end instruction, then retired once.
    cyc(1'b1, 2'b10, 0, 32'd4, 1'b0, 32'h0, 1'b0);
    repeat (4) cyc(1'b0, 2'b10, 0, 32'h0, 1'b0, 32'h30C, 1'b0);
    check("stall_j", 32'(s_jump), 32'h0);
    check("stall_c", s_rdata, 32'd4);
    cyc(1'b0, 2'b10, 0, 32'h0, 1'b1, 32'h30C, 1'b0);
    check("stall_go", 32'(s_jump), 32'h1);
    cyc(1'b0, 2'b10, 0, 32'h0, 1'b0, 32'h30C, 1'b0);
    check("stall_c3", s_rdata, 32'd3);

    // Asynchronous reset between edges with loop 0 active.
    cyc(1'b1, 2'b10, 0, 32'd7, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    bus.cfg_we_i   = 1'b0;
    bus.cfg_sel_i  = 2'b10;
    bus.cfg_idx_i  = '0;
    bus.id_valid_i = 1'b1;
    bus.id_pc_i    = 32'h30C;
    #1;
    check("arst_pre_j", 32'(bus.hwlp_jump_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_j",   32'(bus.hwlp_jump_o),   32'h0);
    check("arst_t",   bus.hwlp_target_o,      32'h0);
    check("arst_act", 32'(bus.hwlp_active_o), 32'h0);
    check("arst_c",   bus.cfg_rdata_o,        32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic over a small address window so loop ends are hit often.
    for (int n = 0; n < 1500; n++) begin
      ridx = $urandom_range(0, N_HWLP - 1);
      rsel = 2'($urandom_range(0, 3));
      if (rsel == 2'b10) rwd = $urandom_range(0, 4);
      else               rwd = 32'h400 + 4 * $urandom_range(0, 7) + $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 6) rpc = m_end[$urandom_range(0, N_HWLP - 1)];
      else                          rpc = 32'h400 + 4 * $urandom_range(0, 7);
      cyc(($urandom_range(0, 4) == 0), rsel, ridx, rwd,
          ($urandom_range(0, 3) != 0), rpc, ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
